// File: rtl/wb_types.sv
// Shared types for the writeback arbiter: register index, data word and
// the buffered long-latency result entry.
package wb_types;
  localparam int NUM_REGS = 32;

  typedef logic [4:0]  regidx_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    regidx_t dest;
    word_t   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline writeback, long-latency result handshake,
// issue/decode busy lookup and the register file write port.
// Handshake: a result transfers on a rising edge where mul_valid && mul_ready;
// mul_ready depends only on registered FIFO occupancy, never on a same-cycle pop.
interface wb_arbiter_if;
  import wb_types::*;

  logic    pipe_load;
  regidx_t pipe_dest;
  word_t   pipe_data;
  logic    mul_valid;
  logic    mul_ready;
  regidx_t mul_dest;
  word_t   mul_data;
  logic    issue_valid;
  regidx_t issue_dest;
  regidx_t src_a;
  regidx_t src_b;
  logic    busy_a;
  logic    busy_b;
  logic    rf_load;
  regidx_t rf_dest;
  word_t   rf_in;
  logic    pipe_stall;

  modport master (
    output pipe_load, pipe_dest, pipe_data,
    output mul_valid, mul_dest, mul_data,
    output issue_valid, issue_dest, src_a, src_b,
    input  mul_ready, busy_a, busy_b, rf_load, rf_dest, rf_in, pipe_stall
  );

  modport slave (
    input  pipe_load, pipe_dest, pipe_data,
    input  mul_valid, mul_dest, mul_data,
    input  issue_valid, issue_dest, src_a, src_b,
    output mul_ready, busy_a, busy_b, rf_load, rf_dest, rf_in, pipe_stall
  );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; pointers wrap modulo DEPTH and
// occupancy is an explicit count so non-power-of-two depths work.
module wb_fifo
  import wb_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline writes own the register file port, buffered
// long-latency results fill idle slots; tracks busy registers and starvation.
module wb_arbiter
  import wb_types::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic                pipe_eff;
  logic                mul_ready;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_entry_t           push_entry, fifo_head;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [SC_W-1:0]     starve_q, starve_d;
  logic                pipe_stall;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    pipe_eff        = !rst && bus.pipe_load && (bus.pipe_dest != '0);
    fifo_pop        = !rst && !pipe_eff && !fifo_empty;
    mul_ready       = !rst && !fifo_full;
    // Results for r0 complete the handshake but are never buffered.
    fifo_push       = bus.mul_valid && mul_ready && (bus.mul_dest != '0);
    push_entry.dest = bus.mul_dest;
    push_entry.data = bus.mul_data;
    pipe_stall      = !rst && (starve_q >= SC_W'(STARVE_LIMIT));
  end

  always_comb begin
    bus.mul_ready  = mul_ready;
    bus.pipe_stall = pipe_stall;
    bus.rf_load    = 1'b0;
    bus.rf_dest    = '0;
    bus.rf_in      = '0;
    if (pipe_eff) begin
      bus.rf_load = 1'b1;
      bus.rf_dest = bus.pipe_dest;
      bus.rf_in   = bus.pipe_data;
    end else if (fifo_pop) begin
      bus.rf_load = 1'b1;
      bus.rf_dest = fifo_head.dest;
      bus.rf_in   = fifo_head.data;
    end
  end

  // A FIFO write of the operand this cycle is forwarded by the register file.
  always_comb begin
    bus.busy_a = !rst && (bus.src_a != '0) && busy_q[bus.src_a] &&
                 !(fifo_pop && (fifo_head.dest == bus.src_a));
    bus.busy_b = !rst && (bus.src_b != '0) && busy_q[bus.src_b] &&
                 !(fifo_pop && (fifo_head.dest == bus.src_b));
  end

  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) busy_d[fifo_head.dest] = 1'b0;
    if (bus.issue_valid && (bus.issue_dest != '0)) busy_d[bus.issue_dest] = 1'b1;
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) starve_d = '0;
    else if (starve_q < SC_W'(STARVE_LIMIT)) starve_d = starve_q + SC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      starve_q <= '0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
    end
  end

  a_issue_not_busy: assert property (@(posedge clk) disable iff (rst)
    !(bus.issue_valid && (bus.issue_dest != '0) && busy_q[bus.issue_dest] &&
      !(fifo_pop && (fifo_head.dest == bus.issue_dest))));

  a_no_load_when_stalled: assert property (@(posedge clk) disable iff (rst)
    !(pipe_stall && bus.pipe_load));
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register file writes are queued as
// stimulus is driven and popped by a monitor whenever rf_load is seen.
module tb_wb_arbiter;
  import wb_types::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [36:0] exp_q[$];

  wb_arbiter_if bus_if ();

  wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every register file write must match the queue head.
  always @(negedge clk) begin
    if (!rst && bus_if.rf_load) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL rf_unexpected observed=%0h expected=none",
               {bus_if.rf_dest, bus_if.rf_in});
      end
      if (exp_q.size() != 0) begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("rf_write", 64'({bus_if.rf_dest, bus_if.rf_in}), 64'(e));
      end
    end
  end

  initial begin
    bus_if.pipe_load   = 1'b0;
    bus_if.pipe_dest   = '0;
    bus_if.pipe_data   = '0;
    bus_if.mul_valid   = 1'b1;
    bus_if.mul_dest    = 5'd1;
    bus_if.mul_data    = 32'h1234;
    bus_if.issue_valid = 1'b0;
    bus_if.issue_dest  = '0;
    bus_if.src_a       = 5'd5;
    bus_if.src_b       = '0;
    rst                = 1'b1;

    // Reset with a result offered
    adv();
    settle();
    chk("rst_mul_ready", 64'(bus_if.mul_ready), 64'(0));
    chk("rst_rf_load", 64'(bus_if.rf_load), 64'(0));
    chk("rst_busy_a", 64'(bus_if.busy_a), 64'(0));
    chk("rst_stall", 64'(bus_if.pipe_stall), 64'(0));
    adv();
    rst = 1'b0;
    bus_if.mul_valid = 1'b0;
    settle();
    chk("rel_mul_ready", 64'(bus_if.mul_ready), 64'(1));
    chk("rel_rf_load", 64'(bus_if.rf_load), 64'(0));

    // Simple result for r5
    adv();
    bus_if.issue_valid = 1'b1;
    bus_if.issue_dest  = 5'd5;
    settle();
    chk("busy_before_set", 64'(bus_if.busy_a), 64'(0));
    adv();
    bus_if.issue_valid = 1'b0;
    bus_if.mul_valid   = 1'b1;
    bus_if.mul_dest    = 5'd5;
    bus_if.mul_data    = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    settle();
    chk("busy_after_issue", 64'(bus_if.busy_a), 64'(1));
    chk("no_bypass", 64'(bus_if.rf_load), 64'(0));
    adv();
    bus_if.mul_valid = 1'b0;
    settle();
    chk("simple_rf_load", 64'(bus_if.rf_load), 64'(1));
    chk("busy_forward", 64'(bus_if.busy_a), 64'(0));
    adv();
    settle();
    chk("busy_cleared", 64'(bus_if.busy_a), 64'(0));
    chk("idle_rf_load", 64'(bus_if.rf_load), 64'(0));

    // Collision: pipeline r7 beats buffered r3
    adv();
    bus_if.mul_valid = 1'b1;
    bus_if.mul_dest  = 5'd3;
    bus_if.mul_data  = 32'h22;
    settle();
    adv();
    bus_if.mul_valid = 1'b0;
    bus_if.pipe_load = 1'b1;
    bus_if.pipe_dest = 5'd7;
    bus_if.pipe_data = 32'h11;
    exp_q.push_back({5'd7, 32'h11});
    exp_q.push_back({5'd3, 32'h22});
    settle();
    chk("coll_pipe_dest", 64'(bus_if.rf_dest), 64'(7));
    adv();
    bus_if.pipe_dest = 5'd0;
    bus_if.pipe_data = 32'h99;
    settle();
    chk("r0_slot_dest", 64'(bus_if.rf_dest), 64'(3));
    adv();
    bus_if.pipe_load = 1'b0;
    settle();
    chk("coll_idle", 64'(bus_if.rf_load), 64'(0));

    // Backpressure and starvation
    for (int i = 0; i < 5; i++) begin
      adv();
      bus_if.pipe_load = 1'b1;
      bus_if.pipe_dest = 5'd10;
      bus_if.pipe_data = 32'h100 + 32'(i);
      bus_if.mul_valid = 1'b1;
      bus_if.mul_dest  = (i < 2) ? 5'(11 + i) : 5'd13;
      bus_if.mul_data  = (i < 2) ? 32'hA0 + 32'(i) : 32'hA2;
      exp_q.push_back({5'd10, 32'h100 + 32'(i)});
      settle();
      chk("bp_mul_ready", 64'(bus_if.mul_ready), 64'(i < 2));
      chk("bp_stall_low", 64'(bus_if.pipe_stall), 64'(0));
    end
    adv();
    bus_if.pipe_load = 1'b0;
    exp_q.push_back({5'd11, 32'hA0});
    settle();
    chk("bp_stall_high", 64'(bus_if.pipe_stall), 64'(1));
    chk("bp_full_ready", 64'(bus_if.mul_ready), 64'(0));
    adv();
    exp_q.push_back({5'd12, 32'hA1});
    settle();
    chk("bp_stall_fall", 64'(bus_if.pipe_stall), 64'(0));
    chk("bp_ready_back", 64'(bus_if.mul_ready), 64'(1));
    adv();
    bus_if.mul_valid = 1'b0;
    exp_q.push_back({5'd13, 32'hA2});
    settle();
    chk("bp_last_load", 64'(bus_if.rf_load), 64'(1));
    adv();
    settle();
    chk("bp_drained", 64'(bus_if.rf_load), 64'(0));

    // Same-edge set and clear of r9
    adv();
    bus_if.issue_valid = 1'b1;
    bus_if.issue_dest  = 5'd9;
    bus_if.src_a       = 5'd9;
    bus_if.src_b       = 5'd9;
    settle();
    adv();
    bus_if.issue_valid = 1'b0;
    bus_if.mul_valid   = 1'b1;
    bus_if.mul_dest    = 5'd9;
    bus_if.mul_data    = 32'h99;
    settle();
    chk("r9_busy", 64'(bus_if.busy_a), 64'(1));
    adv();
    bus_if.mul_valid   = 1'b0;
    bus_if.issue_valid = 1'b1;
    exp_q.push_back({5'd9, 32'h99});
    settle();
    chk("r9_forward", 64'(bus_if.busy_a), 64'(0));
    adv();
    bus_if.issue_valid = 1'b0;
    bus_if.mul_valid   = 1'b1;
    bus_if.mul_data    = 32'h55;
    settle();
    chk("r9_set_wins_a", 64'(bus_if.busy_a), 64'(1));
    chk("r9_set_wins_b", 64'(bus_if.busy_b), 64'(1));
    adv();
    bus_if.mul_valid = 1'b0;
    exp_q.push_back({5'd9, 32'h55});
    settle();
    adv();
    bus_if.src_b = 5'd0;
    settle();
    chk("r9_cleared", 64'(bus_if.busy_a), 64'(0));
    chk("src_b_zero", 64'(bus_if.busy_b), 64'(0));

    // Result for r0 is accepted but never written
    adv();
    bus_if.mul_valid = 1'b1;
    bus_if.mul_dest  = 5'd0;
    bus_if.mul_data  = 32'h77;
    settle();
    chk("r0_ready", 64'(bus_if.mul_ready), 64'(1));
    adv();
    bus_if.mul_valid = 1'b0;
    settle();
    chk("r0_no_write", 64'(bus_if.rf_load), 64'(0));
    chk("r0_still_ready", 64'(bus_if.mul_ready), 64'(1));

    // Reset mid-operation drops the buffered result and busy bits
    adv();
    bus_if.mul_valid   = 1'b1;
    bus_if.mul_dest    = 5'd20;
    bus_if.mul_data    = 32'h1;
    bus_if.issue_valid = 1'b1;
    bus_if.issue_dest  = 5'd21;
    bus_if.src_a       = 5'd21;
    settle();
    adv();
    bus_if.mul_valid   = 1'b0;
    bus_if.issue_valid = 1'b0;
    rst = 1'b1;
    settle();
    chk("mid_rst_rf_load", 64'(bus_if.rf_load), 64'(0));
    chk("mid_rst_busy", 64'(bus_if.busy_a), 64'(0));
    chk("mid_rst_ready", 64'(bus_if.mul_ready), 64'(0));
    adv();
    rst = 1'b0;
    settle();
    chk("post_rst_rf_load", 64'(bus_if.rf_load), 64'(0));
    chk("post_rst_busy", 64'(bus_if.busy_a), 64'(0));
    chk("post_rst_ready", 64'(bus_if.mul_ready), 64'(1));
    adv();
    settle();
    chk("post_rst_idle", 64'(bus_if.rf_load), 64'(0));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and long-latency scoreboard feeding the register file write port (`rf_load`, `rf_dest`, `rf_in`). It merges the in-order pipeline writeback stream with out-of-order results from the multi-cycle multiply/divide unit. Those results are buffered in a small FIFO with a valid/ready handshake. It also tracks per-register busy bits so decode can stall on operands still owned by the long-latency unit.

## Interface
- `FIFO_DEPTH`, 2: long-latency result buffer entries (≥1).
- `STARVE_LIMIT`, 4: cycles a FIFO head may lose arbitration before `pipe_stall` asserts.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pipe_load` in 1: pipeline WB write request.
- `pipe_dest` in 5: pipeline WB destination.
- `pipe_data` in 32: pipeline WB data.
- `mul_valid` in 1: long-latency result valid.
- `mul_ready` out 1: arbiter can accept a result.
- `mul_dest` in 5: result destination.
- `mul_data` in 32: result data.
- `issue_valid` in 1: long-latency op issued this cycle.
- `issue_dest` in 5: destination of the issued op.
- `src_a`, `src_b` in 5 each: decode operand indices.
- `busy_a`, `busy_b` out 1 each: operand still pending.
- `rf_load` out 1: register file write enable.
- `rf_dest` out 5: register file write index.
- `rf_in` out 32: register file write data.
- `pipe_stall` out 1: upstream must hold off pipeline writeback.

## Operation
- **Pipeline writes.** A pipeline write is effective when `pipe_load && pipe_dest != 0`. It always wins the write port and has no backpressure.
- **Port arbitration.** Effective pipeline write: `rf_load=1`, `rf_dest=pipe_dest`, `rf_in=pipe_data`. Otherwise, if the FIFO is non-empty: drive the head entry and pop it at the edge. Otherwise: `rf_load=0`, `rf_dest=0`, `rf_in=0`.
- `pipe_load` with `pipe_dest==0` is a no-op and leaves the slot free for the FIFO.
- **Long-latency handshake.** Transfer occurs on `mul_valid && mul_ready` at a rising edge. `mul_ready = !full`, registered-state only, with no same-cycle pop credit. A full FIFO refuses even if it pops this cycle.
- An accepted result with `mul_dest==0` is dropped and not pushed.
- No FIFO bypass: an accepted result always enters the FIFO first.
- **Busy bits** (32 × 1).
  - Set at the edge when `issue_valid && issue_dest != 0`.
  - Cleared at the edge when that register is written from the FIFO.
  - Same-edge set and clear of the same index: set wins.
  - Issue to an already-busy register is illegal. Checked by assertion; the bit stays set.
- **Busy outputs.** `busy_x = busy[src_x]`, forced 0 when `src_x==0`. Also forced 0 when the FIFO is writing `src_x` this cycle, matching the register file's write-through forwarding.
- **Starvation.** The counter increments each cycle the FIFO is non-empty and the head is not popped; it clears on pop or when the FIFO is empty.
  - `pipe_stall = (starve_cnt >= STARVE_LIMIT)`, decoded from the registered counter.
  - Upstream must hold `pipe_load=0` while `pipe_stall=1`. If violated, the pipeline still wins and an assertion fires.
  - The counter saturates at `STARVE_LIMIT`.
- **Reset.** FIFO empty, all busy bits 0, counter 0.
  - While `rst=1`: `mul_ready=0`, `rf_load=0`, `busy_a=busy_b=0`, `pipe_stall=0`.
  - Reset mid-operation discards buffered results with no register write.

## Timing
- Pipeline path is combinational: `pipe_*` to `rf_*` in the same cycle, committed at the next edge.
- Result accepted at edge E: earliest `rf_load` for it is in the cycle after E, committed at edge E+1.
- `busy` set at the issue edge is visible on `busy_a/b` in the following cycle.
- `mul_ready` updates the cycle after a push or pop changes occupancy.
- `pipe_stall` rises the cycle after the counter reaches `STARVE_LIMIT`. It falls the cycle after the head pops.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Occupancy is tracked by a count of width clog2(`FIFO_DEPTH`+1).

## Structure
- Package `wb_types`:
  - `regidx_t` (5-bit).
  - `word_t` (32-bit).
  - `wb_entry_t` struct {`dest`, `data`}.
  - `NUM_REGS=32`.
- One sub-module, `wb_fifo`: parameterised sync FIFO of `wb_entry_t` with push/pop/full/empty/head.
- Busy bits, arbitration and starvation counter live in `wb_arbiter`.

## Test plan
- **Reset.** Assert `rst` with `mul_valid=1` → `mul_ready=0`, `rf_load=0`, all busy 0. Release → `mul_ready=1` next cycle.
- **Simple result.** `issue_valid`, `issue_dest=5`; then `busy_a=1` for `src_a=5`. Accept {5, 0xDEADBEEF} with the pipeline idle → next cycle `rf_load=1`, `rf_dest=5`, `rf_in=0xDEADBEEF`, `busy_a=0` that cycle.
- **Collision.** Pipeline writes {7, 0x11} while the FIFO holds {3, 0x22} → r7 written first, r3 the following cycle. `pipe_dest=0` with FIFO non-empty → FIFO entry written.
- **Backpressure.** Fill FIFO (2 entries) with the pipeline writing every cycle → `mul_ready=0`. 4 blocked cycles → `pipe_stall=1`. Drop `pipe_load` → head pops, `pipe_stall=0` next cycle.
- **Busy edge cases.** Same-edge issue to r9 and FIFO write of r9 → busy[9] stays 1. Result with `mul_dest=0` → accepted, no `rf_load`.
